// File: rtl/grom_core_if.sv
// grom memory/IO bus: 12-bit address, 8-bit data each way, write strobe, IO qualifier, halt status.
// Latency: none; this only bundles the wires between the core and the memory/IO fabric.
// Backpressure: none; the slave must return read data exactly MEM_LAT cycles after addr.
interface grom_core_if;
    logic [11:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        we;
    logic        ioreq;
    logic        hlt;

    modport master (output addr, data_out, we, ioreq, hlt, input data_in);
    modport slave  (input addr, data_out, we, ioreq, hlt, output data_in);
endinterface

// File: rtl/grom_core.sv
// grom_core: multi-cycle 8-bit CPU with ALU flags, segmented LOAD/STORE, jumps, LDI and port IO.
// Latency: 3+L per one-byte op, 5+2L per two-byte op, plus L+1 (writes) or L+2 (reads) for bus accesses.
// Backpressure: none; every bus access simply waits a fixed MEM_LAT cycles before data is used.
module grom_core #(
    parameter int unsigned MEM_LAT  = 1,
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    grom_core_if.master bus
);

    localparam logic [3:0] FETCH_PREP = 4'd0;
    localparam logic [3:0] FETCH_WAIT = 4'd1;
    localparam logic [3:0] FETCH      = 4'd2;
    localparam logic [3:0] OP_PREP    = 4'd3;
    localparam logic [3:0] OP_WAIT    = 4'd4;
    localparam logic [3:0] OP_FETCH   = 4'd5;
    localparam logic [3:0] EXECUTE    = 4'd6;
    localparam logic [3:0] MEM_WAIT   = 4'd7;
    localparam logic [3:0] WRITEBACK  = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  op_q, op_d;
    logic [3:0]  seg_q, seg_d;
    logic [7:0]  r_q [4];
    logic [7:0]  r_d [4];
    logic        c_q, c_d;
    logic        z_q, z_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        we_q, we_d;
    logic        ioreq_q, ioreq_d;
    logic        hlt_q, hlt_d;

    logic [1:0]  fd, fs;
    logic [7:0]  rs, rd;
    logic        is_write, is_in;

    assign fd = ir_q[3:2];
    assign fs = ir_q[1:0];
    assign rs = r_q[fs];
    assign rd = r_q[fd];
    // STORE and OUT are the only writes; IN is the only read that targets Rs.
    assign is_write = (ir_q[7:4] == 4'h6) || ((ir_q[7:4] == 4'hE) && ir_q[2]);
    assign is_in    = (ir_q[7:4] == 4'hE) && !ir_q[2];

    assign bus.addr     = addr_q;
    assign bus.data_out = dout_q;
    assign bus.we       = we_q;
    assign bus.ioreq    = ioreq_q;
    assign bus.hlt      = hlt_q;

    logic [8:0] sum;
    logic [7:0] res;
    logic [8:0] cin;

    // Next-state logic: sequencing of fetch/operand/execute/bus phases and the ALU.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        op_d    = op_q;
        seg_d   = seg_q;
        r_d     = r_q;
        c_d     = c_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        we_d    = we_q;
        ioreq_d = ioreq_q;
        hlt_d   = hlt_q;
        sum     = '0;
        res     = '0;
        cin     = {8'h00, (fd[1] & c_q)};

        case (state_q)
            FETCH_PREP: begin
                we_d    = 1'b0;
                ioreq_d = 1'b0;
                // A halted core parks here with addr left on the HLT opcode.
                if (!hlt_q) begin
                    addr_d  = pc_q;
                    cnt_d   = 5'(MEM_LAT);
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (cnt_q == 5'd1) state_d = FETCH;
                else               cnt_d   = cnt_q - 5'd1;
            end
            FETCH: begin
                ir_d    = bus.data_in;
                pc_d    = pc_q + 12'd1;
                state_d = bus.data_in[7] ? OP_PREP : EXECUTE;
            end
            OP_PREP: begin
                addr_d  = pc_q;
                cnt_d   = 5'(MEM_LAT);
                state_d = OP_WAIT;
            end
            OP_WAIT: begin
                if (cnt_q == 5'd1) state_d = OP_FETCH;
                else               cnt_d   = cnt_q - 5'd1;
            end
            OP_FETCH: begin
                op_d    = bus.data_in;
                pc_d    = pc_q + 12'd1;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                state_d = FETCH_PREP;
                if (ir_q[7]) begin
                    case (ir_q[6:4])
                        3'd0: pc_d = {ir_q[3:0], op_q};
                        3'd1: if (c_q)  pc_d = {ir_q[3:0], op_q};
                        3'd2: if (!c_q) pc_d = {ir_q[3:0], op_q};
                        3'd3: if (z_q)  pc_d = {ir_q[3:0], op_q};
                        3'd4: if (!z_q) pc_d = {ir_q[3:0], op_q};
                        3'd5: r_d[fs] = op_q;
                        3'd6: begin
                            addr_d  = {4'h0, op_q};
                            ioreq_d = 1'b1;
                            we_d    = ir_q[2];
                            if (ir_q[2]) dout_d = rs;
                            // Reads get one cycle beyond MEM_LAT before capture.
                            cnt_d   = ir_q[2] ? 5'(MEM_LAT) : 5'(MEM_LAT + 1);
                            state_d = MEM_WAIT;
                        end
                        default: ;
                    endcase
                end else begin
                    case (ir_q[6:4])
                        3'd0: r_d[fd] = rs;
                        3'd1: begin
                            case (fd)
                                2'd0: res = 8'h00;
                                2'd1: res = rs + 8'd1;
                                2'd2: res = rs - 8'd1;
                                default: res = ~rs;
                            endcase
                            r_d[fs] = res;
                            if (fd == 2'd1 || fd == 2'd2) z_d = (res == 8'h00);
                        end
                        3'd2: begin
                            if (fd[0]) sum = {1'b0, r_q[0]} - {1'b0, rs} - cin;
                            else       sum = {1'b0, r_q[0]} + {1'b0, rs} + cin;
                            r_d[0] = sum[7:0];
                            c_d    = sum[8];
                            z_d    = (sum[7:0] == 8'h00);
                        end
                        3'd3: begin
                            case (fd)
                                2'd0: res = r_q[0] & rs;
                                2'd1: res = r_q[0] | rs;
                                2'd2: res = r_q[0] ^ rs;
                                default: begin
                                    sum = {1'b0, r_q[0]} - {1'b0, rs};
                                    res = sum[7:0];
                                end
                            endcase
                            // CMP keeps R0 and reports borrow; logic ops clear C.
                            if (fd != 2'd3) r_d[0] = res;
                            c_d = (fd == 2'd3) ? sum[8] : 1'b0;
                            z_d = (res == 8'h00);
                        end
                        3'd4: begin
                            case (fd)
                                2'd0: res = {rs[6:0], 1'b0};
                                2'd1: res = {1'b0, rs[7:1]};
                                2'd2: res = {rs[6:0], rs[7]};
                                default: res = {rs[0], rs[7:1]};
                            endcase
                            r_d[fs] = res;
                            c_d     = fd[0] ? rs[0] : rs[7];
                            z_d     = (res == 8'h00);
                        end
                        3'd5: begin
                            addr_d  = {seg_q, rs};
                            we_d    = 1'b0;
                            ioreq_d = 1'b0;
                            cnt_d   = 5'(MEM_LAT + 1);
                            state_d = MEM_WAIT;
                        end
                        3'd6: begin
                            addr_d  = {seg_q, rs};
                            dout_d  = rd;
                            we_d    = 1'b1;
                            ioreq_d = 1'b0;
                            cnt_d   = 5'(MEM_LAT);
                            state_d = MEM_WAIT;
                        end
                        default: begin
                            case (fd)
                                2'd0: seg_d   = rs[3:0];
                                2'd1: r_d[fs] = {4'h0, seg_q};
                                2'd2: seg_d   = 4'h0;
                                default: hlt_d = 1'b1;
                            endcase
                        end
                    endcase
                end
            end
            MEM_WAIT: begin
                // Write strobe lasts exactly one cycle; addr/ioreq stay for the wait.
                we_d = 1'b0;
                if (cnt_q == 5'd1) begin
                    state_d = WRITEBACK;
                    if (is_write) ioreq_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            WRITEBACK: begin
                if (!is_write) begin
                    if (is_in) r_d[fs] = bus.data_in;
                    else       r_d[fd] = bus.data_in;
                end
                ioreq_d = 1'b0;
                state_d = FETCH_PREP;
            end
            default: state_d = FETCH_PREP;
        endcase
    end

    // State registers with synchronous reset that overrides any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_PREP;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            op_q    <= '0;
            seg_q   <= '0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            ioreq_q <= 1'b0;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_q    <= op_d;
            seg_q   <= seg_d;
            r_q     <= r_d;
            c_q     <= c_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            ioreq_q <= ioreq_d;
            hlt_q   <= hlt_d;
        end
    end

endmodule

// File: tb/tb_grom_core.sv
// Bench for grom_core: two cores (MEM_LAT 1 and 3) run the same directed programs.
// Memory model returns data MEM_LAT cycles after addr; writes land in a per-core RAM overlay.
// Expected registers, flags, bus values and cycle counts are hand-computed constants.
module tb_grom_core;
    logic clk;
    logic reset;
    logic clr_ram;
    logic [7:0] io_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    grom_core_if bus0 ();
    grom_core_if bus1 ();

    grom_core #(.MEM_LAT(1), .RESET_PC(12'h000)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    grom_core #(.MEM_LAT(3), .RESET_PC(12'h000)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic [7:0]  rom  [4096];
    logic [7:0]  ram0 [4096];
    logic [7:0]  ram1 [4096];
    logic        wv0  [4096];
    logic        wv1  [4096];
    logic [12:0] p0;
    logic [12:0] p1 [3];
    int          we_cnt0, we_run0, we_max0, we_run1, we_max1;
    logic [11:0] we_addr0;
    logic [7:0]  we_dat0;
    logic        we_io0;
    int          errors = 0;
    int          checks = 0;

    assign bus0.data_in = p0[12] ? io_val : (wv0[p0[11:0]] ? ram0[p0[11:0]] : rom[p0[11:0]]);
    assign bus1.data_in = p1[2][12] ? io_val : (wv1[p1[2][11:0]] ? ram1[p1[2][11:0]] : rom[p1[2][11:0]]);

    always @(posedge clk) begin
        p0    <= {bus0.ioreq, bus0.addr};
        p1[0] <= {bus1.ioreq, bus1.addr};
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        if (clr_ram) begin
            for (int i = 0; i < 4096; i++) begin
                wv0[i] <= 1'b0;
                wv1[i] <= 1'b0;
            end
            we_cnt0 <= 0; we_run0 <= 0; we_max0 <= 0; we_run1 <= 0; we_max1 <= 0;
            we_addr0 <= '0; we_dat0 <= '0; we_io0 <= 1'b0;
        end else begin
            if (bus0.we && !bus0.ioreq) begin
                ram0[bus0.addr] <= bus0.data_out;
                wv0[bus0.addr]  <= 1'b1;
            end
            if (bus1.we && !bus1.ioreq) begin
                ram1[bus1.addr] <= bus1.data_out;
                wv1[bus1.addr]  <= 1'b1;
            end
            if (bus0.we) begin
                we_cnt0  <= we_cnt0 + 1;
                we_addr0 <= bus0.addr;
                we_dat0  <= bus0.data_out;
                we_io0   <= bus0.ioreq;
                we_run0  <= we_run0 + 1;
                if (we_run0 + 1 > we_max0) we_max0 <= we_run0 + 1;
            end else begin
                we_run0 <= 0;
            end
            if (bus1.we) begin
                we_run1 <= we_run1 + 1;
                if (we_run1 + 1 > we_max1) we_max1 <= we_run1 + 1;
            end else begin
                we_run1 <= 0;
            end
        end
    end

    task automatic load_prog(input logic [127:0] p, input int n);
        for (int i = 0; i < 4096; i++) rom[i] = 8'h7F;
        for (int i = 0; i < n; i++) rom[i] = p[(n-1-i)*8 +: 8];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        clr_ram = 1'b1;
        repeat (3) @(negedge clk);
        clr_ram = 1'b0;
        reset = 1'b0;
    endtask

    task automatic wait_hlt(output int t0, output int t1);
        int n;
        t0 = -1; t1 = -1; n = 0;
        while ((t0 < 0 || t1 < 0) && n < 2000) begin
            @(negedge clk);
            n++;
            if (t0 < 0 && bus0.hlt === 1'b1) t0 = n;
            if (t1 < 0 && bus1.hlt === 1'b1) t1 = n;
        end
        checks++;
        if (t0 < 0 || t1 < 0) begin
            errors++;
            $display("FAIL halt_timeout: t0=%0d t1=%0d, required both to halt", t0, t1);
        end
    endtask

    task automatic test_reset();
        load_prog(128'h1014147F, 4);
        @(negedge clk);
        reset = 1'b1;
        clr_ram = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus0.addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", bus0.addr); end
        checks++; if (bus0.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus0.we); end
        checks++; if (bus0.ioreq !== 1'b0) begin errors++; $display("FAIL reset_ioreq: got %b expected 0", bus0.ioreq); end
        checks++; if (bus0.hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt: got %b expected 0", bus0.hlt); end
        checks++; if (u_dut0.pc_q !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", u_dut0.pc_q); end
        checks++; if (u_dut0.r_q[2] !== 8'h00) begin errors++; $display("FAIL reset_r2: got %h expected 00", u_dut0.r_q[2]); end
        clr_ram = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_halt();
        int t0, t1;
        load_prog(128'h1014147F, 4);
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (t0 !== 16) begin errors++; $display("FAIL halt_cycles_l1: got %0d expected 16", t0); end
        checks++; if (t1 !== 24) begin errors++; $display("FAIL halt_cycles_l3: got %0d expected 24", t1); end
        checks++; if (u_dut0.r_q[0] !== 8'h02) begin errors++; $display("FAIL halt_r0: got %h expected 02", u_dut0.r_q[0]); end
        checks++; if (u_dut1.r_q[0] !== 8'h02) begin errors++; $display("FAIL halt_r0_l3: got %h expected 02", u_dut1.r_q[0]); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.addr !== 12'h003 || bus0.hlt !== 1'b1 || bus0.we !== 1'b0 || bus0.ioreq !== 1'b0) begin
                errors++;
                $display("FAIL halt_park: cycle %0d addr=%h hlt=%b we=%b ioreq=%b, required 003/1/0/0",
                         i, bus0.addr, bus0.hlt, bus0.we, bus0.ioreq);
            end
        end
    endtask

    task automatic test_arith();
        int t0, t1;
        load_prog(128'hD0F0D120217F, 6);
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (u_dut0.r_q[0] !== 8'h10) begin errors++; $display("FAIL add_r0: got %h expected 10", u_dut0.r_q[0]); end
        checks++; if (u_dut0.c_q !== 1'b1) begin errors++; $display("FAIL add_c: got %b expected 1", u_dut0.c_q); end
        checks++; if (u_dut0.z_q !== 1'b0) begin errors++; $display("FAIL add_z: got %b expected 0", u_dut0.z_q); end
        load_prog(128'hD010D120257F, 6);
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (u_dut0.r_q[0] !== 8'hF0) begin errors++; $display("FAIL sub_r0: got %h expected F0", u_dut0.r_q[0]); end
        checks++; if (u_dut0.c_q !== 1'b1) begin errors++; $display("FAIL sub_c: got %b expected 1", u_dut0.c_q); end
        checks++; if (u_dut0.z_q !== 1'b0) begin errors++; $display("FAIL sub_z: got %b expected 0", u_dut0.z_q); end
    endtask

    task automatic test_incdec_wrap();
        int t0, t1;
        load_prog(128'hD10019D0FF147F, 7);
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (u_dut0.r_q[1] !== 8'hFF) begin errors++; $display("FAIL dec_wrap: got %h expected FF", u_dut0.r_q[1]); end
        checks++; if (u_dut0.r_q[0] !== 8'h00) begin errors++; $display("FAIL inc_wrap: got %h expected 00", u_dut0.r_q[0]); end
        checks++; if (u_dut0.z_q !== 1'b1) begin errors++; $display("FAIL inc_z: got %b expected 1", u_dut0.z_q); end
        checks++; if (u_dut0.c_q !== 1'b0) begin errors++; $display("FAIL inc_c_kept: got %b expected 0", u_dut0.c_q); end
    endtask

    task automatic test_shift();
        int t0, t1;
        load_prog(128'hD38143D2814E7F, 7);
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (u_dut0.r_q[3] !== 8'h02) begin errors++; $display("FAIL shl_r3: got %h expected 02", u_dut0.r_q[3]); end
        checks++; if (u_dut0.r_q[2] !== 8'hC0) begin errors++; $display("FAIL ror_r2: got %h expected C0", u_dut0.r_q[2]); end
        checks++; if (u_dut0.c_q !== 1'b1) begin errors++; $display("FAIL ror_c: got %b expected 1", u_dut0.c_q); end
    endtask

    task automatic test_load_store();
        int t0, t1;
        load_prog(128'hD33CD10571D2806E527F, 10);
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (t0 !== 42) begin errors++; $display("FAIL ls_cycles_l1: got %0d expected 42", t0); end
        checks++; if (t1 !== 66) begin errors++; $display("FAIL ls_cycles_l3: got %0d expected 66", t1); end
        checks++; if (we_cnt0 !== 1) begin errors++; $display("FAIL st_we_count: got %0d expected 1", we_cnt0); end
        checks++; if (we_max0 !== 1) begin errors++; $display("FAIL st_we_width: got %0d expected 1", we_max0); end
        checks++; if (we_max1 !== 1) begin errors++; $display("FAIL st_we_width_l3: got %0d expected 1", we_max1); end
        checks++; if (we_addr0 !== 12'h580) begin errors++; $display("FAIL st_addr: got %h expected 580", we_addr0); end
        checks++; if (we_dat0 !== 8'h3C || we_io0 !== 1'b0) begin errors++; $display("FAIL st_data: got %h io=%b expected 3C io=0", we_dat0, we_io0); end
        checks++; if (ram1[12'h580] !== 8'h3C) begin errors++; $display("FAIL st_mem_l3: got %h expected 3C", ram1[12'h580]); end
        checks++; if (u_dut0.r_q[0] !== 8'h3C) begin errors++; $display("FAIL ld_r0_l1: got %h expected 3C", u_dut0.r_q[0]); end
        checks++; if (u_dut1.r_q[0] !== 8'h3C) begin errors++; $display("FAIL ld_r0_l3: got %h expected 3C", u_dut1.r_q[0]); end
    endtask

    task automatic test_cmp_jump();
        int t0, t1;
        load_prog(128'hD033D1333DB123, 7);
        rom[12'h123] = 8'hC2;
        rom[12'h124] = 8'h00;
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (u_dut0.r_q[0] !== 8'h33) begin errors++; $display("FAIL cmp_r0: got %h expected 33", u_dut0.r_q[0]); end
        checks++; if (u_dut0.z_q !== 1'b1 || u_dut0.c_q !== 1'b0) begin errors++; $display("FAIL cmp_flags: got z=%b c=%b expected z=1 c=0", u_dut0.z_q, u_dut0.c_q); end
        checks++; if (bus0.addr !== 12'h125) begin errors++; $display("FAIL jz_jnz_addr: got %h expected 125", bus0.addr); end
        checks++; if (bus1.addr !== 12'h125) begin errors++; $display("FAIL jz_jnz_addr_l3: got %h expected 125", bus1.addr); end
    endtask

    task automatic test_io();
        int t0, t1;
        io_val = 8'hA5;
        load_prog(128'hD15AE542E1427F, 7);
        apply_reset();
        wait_hlt(t0, t1);
        checks++; if (t0 !== 30) begin errors++; $display("FAIL io_cycles_l1: got %0d expected 30", t0); end
        checks++; if (t1 !== 48) begin errors++; $display("FAIL io_cycles_l3: got %0d expected 48", t1); end
        checks++; if (we_cnt0 !== 1) begin errors++; $display("FAIL io_we_count: got %0d expected 1", we_cnt0); end
        checks++; if (we_addr0 !== 12'h042 || we_io0 !== 1'b1) begin errors++; $display("FAIL out_addr: got %h io=%b expected 042 io=1", we_addr0, we_io0); end
        checks++; if (we_dat0 !== 8'h5A) begin errors++; $display("FAIL out_data: got %h expected 5A", we_dat0); end
        checks++; if (u_dut0.r_q[1] !== 8'hA5) begin errors++; $display("FAIL in_r1: got %h expected A5", u_dut0.r_q[1]); end
        checks++; if (u_dut1.r_q[1] !== 8'hA5) begin errors++; $display("FAIL in_r1_l3: got %h expected A5", u_dut1.r_q[1]); end
    endtask

    task automatic test_reset_mid_store();
        int t0, t1, n;
        load_prog(128'hD33CD10571D2806E527F, 10);
        apply_reset();
        n = 0;
        while (bus0.we !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus0.we !== 1'b1) begin errors++; $display("FAIL mid_store_seen: got we=%b expected 1", bus0.we); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus0.we !== 1'b0 || bus0.ioreq !== 1'b0) begin errors++; $display("FAIL mid_reset_bus: got we=%b ioreq=%b expected 0/0", bus0.we, bus0.ioreq); end
        checks++; if (u_dut0.pc_q !== 12'h000) begin errors++; $display("FAIL mid_reset_pc: got %h expected 000", u_dut0.pc_q); end
        checks++; if (bus0.addr !== 12'h000) begin errors++; $display("FAIL mid_reset_addr: got %h expected 000", bus0.addr); end
        reset = 1'b0;
        wait_hlt(t0, t1);
        checks++; if (t0 !== 42) begin errors++; $display("FAIL restart_cycles: got %0d expected 42", t0); end
        checks++; if (u_dut0.r_q[0] !== 8'h3C) begin errors++; $display("FAIL restart_r0: got %h expected 3C", u_dut0.r_q[0]); end
    endtask

    initial begin
        reset = 1'b1;
        clr_ram = 1'b0;
        io_val = 8'h00;
        test_reset();
        test_halt();
        test_arith();
        test_incdec_wrap();
        test_shift();
        test_load_store();
        test_cmp_jump();
        test_io();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
